// File: rtl/ifetch_q_pkg.sv
// Shared defaults for the fetch stage, ID and instruction memory.
// Also holds the width helper used to size the queue occupancy counter.
package ifetch_q_pkg;

    localparam int unsigned ADDR_W_DEF   = 16;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam int unsigned RESET_PC_DEF = 0;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_q_fetch_fifo.sv
// Synchronous FIFO of {inst, pc} entries with synchronous flush.
// Power-of-2 depth so the pointers wrap by natural overflow.
module ifetch_q_fetch_fifo
    import ifetch_q_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = DATA_W_DEF + ADDR_W_DEF,
    localparam int unsigned CNT_W = cnt_w(DEPTH),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full & ~flush & ~rst;
    assign do_pop  = pop & ~empty & ~flush & ~rst;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; flushing the pointers is enough.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (count <= CNT_W'(DEPTH));
            assert (!(push && full && !flush));
        end
    end

endmodule

// File: rtl/ifetch_q.sv
// Instruction fetch with a credit-limited decoupling queue in front of ID.
// Redirect flushes the queue and drops the fetch that is in flight.
module ifetch_q
    import ifetch_q_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] baddr_i,
    input  logic              stall_i,
    output logic              v_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [ADDR_W-1:0]        pc_r;
    logic [ADDR_W-1:0]        inflight_pc_r;
    logic                     inflight_r;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     full;
    logic [DATA_W+ADDR_W-1:0] head;
    logic [CNT_W:0]           occupancy;
    logic                     push;
    logic                     pop;

    // Credit ignores a same-cycle dequeue: conservative, never overflows.
    assign occupancy   = {1'b0, count} + (CNT_W+1)'(inflight_r);
    assign imem_req_o  = ~rst & ~branch_i & (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = pc_r;

    assign push   = inflight_r & ~branch_i & ~rst;
    assign v_o    = ~empty & ~branch_i & ~rst;
    assign pop    = v_o & ~stall_i;
    assign inst_o = head[ADDR_W +: DATA_W];
    assign pc_o   = head[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= RESET_PC;
        end else if (branch_i) begin
            pc_r       <= baddr_i;
            inflight_r <= 1'b0;
        end else if (imem_req_o) begin
            pc_r          <= pc_r + ADDR_W'(1);
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    ifetch_q_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_i),
        .push  (push),
        .pop   (pop),
        .din   ({imem_data_i, inflight_pc_r}),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_ifetch_q.sv
// Bench for ifetch_q: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_ifetch_q;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_data_i;
    logic          branch_i;
    logic [AW-1:0] baddr_i;
    logic          stall_i;
    logic          v_o;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] pc_o;

    int vectors = 0;
    int errors  = 0;

    ifetch_q #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_i (imem_data_i),
        .branch_i    (branch_i),
        .baddr_i     (baddr_i),
        .stall_i     (stall_i),
        .v_o         (v_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a ^ 16'hBEEF, a + 16'h0100};
    endfunction

    // One-cycle-latency memory: returns data for whatever address was driven.
    logic [AW-1:0] mem_addr_q = '0;
    always @(posedge clk) mem_addr_q <= imem_addr_o;
    assign imem_data_i = mem_fn(mem_addr_q);

    typedef struct {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_pc       = '0;
    logic          m_infl     = 1'b0;
    logic [AW-1:0] m_infl_pc  = '0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic b, input logic [AW-1:0] ba, input logic s);
        logic exp_v;
        logic exp_req;
        ent_t e;
        rst      = r;
        branch_i = b;
        baddr_i  = ba;
        stall_i  = s;
        #1;
        exp_v   = !r && !b && (mq.size() != 0);
        exp_req = !r && !b && ((mq.size() + int'(m_infl)) < DEPTH);
        check_bit("v_o", v_o, exp_v);
        check_bit("imem_req_o", imem_req_o, exp_req);
        if (exp_v) begin
            check_val("inst_o", inst_o, mq[0].inst);
            check_val("pc_o", {16'h0, pc_o}, {16'h0, mq[0].pc});
        end
        if (exp_req) check_val("imem_addr_o", {16'h0, imem_addr_o}, {16'h0, m_pc});
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_pc   = '0;
            m_infl = 1'b0;
        end else if (b) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = ba;
        end else begin
            if (exp_v && !s) void'(mq.pop_front());
            if (m_infl) begin
                e.inst = mem_fn(m_infl_pc);
                e.pc   = m_infl_pc;
                mq.push_back(e);
            end
            if (exp_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 16'd1;
                m_infl    = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        branch_i = 1'b0;
        baddr_i  = '0;
        stall_i  = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
        // Startup streaming.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Stall fill and release.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Redirect mid-stream.
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Branch + stall with queue full.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 16'h0123, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Branch + stall with a return landing the same cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 16'h0200, 1'b1);
        // Back-to-back and early re-branches.
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 16'h0400, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Address wrap.
        step(1'b0, 1'b1, 16'hFFFE, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);
        // Mid-stream reset with entries queued and a fetch in flight.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic b;
            logic s;
            r = ($urandom_range(99) < 2);
            b = ($urandom_range(99) < 10);
            s = ($urandom_range(99) < 35);
            step(r, b, 16'($urandom), s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
